// File: rtl/obi_pkg.sv
// Shared types and constants for the OBI block-copy initiator.
// Holds the FSM state encoding and the default word geometry.
package obi_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int WORD_BYTES = DATA_W_DEF / 8;
    localparam logic [WORD_BYTES-1:0] BE_ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } obi_copy_state_e;

endpackage

// File: rtl/obi_if.sv
// OBI request and response channel interfaces.
// The request side carries the handshake; the response side is one-way.
interface obi_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  req;
    logic                  gnt;
    logic [ADDR_W-1:0]     addr;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt
    );
endinterface

interface obi_rsp_if #(
    parameter int DATA_W = 32
) ();
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output rvalid, rdata
    );

    modport slave (
        input rvalid, rdata
    );
endinterface

// File: rtl/obi_copy_master.sv
// OBI initiator copying a block of words from src to dst.
// One outstanding transaction; every read is followed by its write.
module obi_copy_master
    import obi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    obi_req_if.master         req,
    obi_rsp_if.slave          rsp
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
    localparam logic [LEN_W-1:0]  ONE    = LEN_W'(1);

    obi_copy_state_e   state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Next-state and datapath updates; bus fields are set on entry to a request state.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        src_d   = src_addr_i;
                        dst_d   = dst_addr_i;
                        rem_d   = len_i;
                        addr_d  = src_addr_i;
                        we_d    = 1'b0;
                        be_d    = '1;
                        state_d = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_REQ: begin
                if (req.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rsp.rvalid) begin
                    wdata_d = rsp.rdata;
                    addr_d  = dst_q;
                    we_d    = 1'b1;
                    be_d    = '1;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (req.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (rsp.rvalid) begin
                    src_d = src_q + STRIDE;
                    dst_d = dst_q + STRIDE;
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = src_q + STRIDE;
                        we_d    = 1'b0;
                        be_d    = '1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Status and bus outputs decoded from registered state only.
    always_comb begin
        req.req   = (state_q == RD_REQ) || (state_q == WR_REQ);
        req.addr  = addr_q;
        req.we    = we_q;
        req.be    = be_q;
        req.wdata = wdata_q;
        busy_o    = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                    (state_q == WR_REQ) || (state_q == WR_WAIT);
        done_o    = (state_q == DONE);
    end

endmodule

// File: tb/tb_obi_copy_master.sv
// Self-checking bench for obi_copy_master against a 1-cycle SRAM slave.
// Expected bus traffic is queued at start and compared at each handshake.
module tb_obi_copy_master;
    import obi_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;

    obi_req_if #(.ADDR_W(AW), .DATA_W(DW)) req_if ();
    obi_rsp_if #(.DATA_W(DW)) rsp_if ();

    obi_copy_master #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .LEN_W (LW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .src_addr_i(src),
        .dst_addr_i(dst),
        .len_i     (len),
        .busy_o    (busy),
        .done_o    (done),
        .req       (req_if),
        .rsp       (rsp_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] mem   [0:1023];
    logic [DW-1:0] model [0:1023];
    int            stall_n = 0;
    int            stall_cnt = 0;
    logic          pl_en = 1'b0;
    logic [9:0]    pl_idx = '0;
    logic [DW-1:0] pl_data = '0;

    assign req_if.gnt = req_if.req && (stall_cnt >= stall_n);

    // SRAM slave: grant after stall_n waiting cycles, respond one cycle later.
    always @(posedge clk) begin
        rsp_if.rvalid <= 1'b0;
        if (pl_en) mem[pl_idx] <= pl_data;
        if (rst) begin
            stall_cnt <= 0;
        end else if (req_if.req) begin
            if (req_if.gnt) begin
                stall_cnt     <= 0;
                rsp_if.rvalid <= 1'b1;
                if (req_if.we) mem[req_if.addr[11:2]] <= req_if.wdata;
                else rsp_if.rdata <= mem[req_if.addr[11:2]];
            end else begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    logic [AW-1:0] exp_rd [$];
    wr_t           exp_wr [$];
    int            done_cnt = 0;
    int            req_cnt  = 0;
    int            busy_cnt = 0;
    logic          hold_v   = 1'b0;
    logic [AW-1:0] hold_addr;
    logic          hold_we;
    logic [DW-1:0] hold_wdata;

    // Bus monitor: scoreboard handshakes and check request stability.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (req_if.req) req_cnt++;
        if (busy) busy_cnt++;
        if (hold_v && req_if.req) begin
            check("hold_addr", 32'(req_if.addr), 32'(hold_addr));
            check("hold_we", 32'(req_if.we), 32'(hold_we));
            if (hold_we) check("hold_wdata", req_if.wdata, hold_wdata);
        end
        if (req_if.req && req_if.gnt) begin
            check("hs_be", 32'(req_if.be), 32'hF);
            if (req_if.we) begin
                check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(req_if.addr), 32'(w.addr));
                    check("wr_data", req_if.wdata, w.data);
                end
            end else begin
                check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) begin
                    logic [AW-1:0] a;
                    a = exp_rd.pop_front();
                    check("rd_addr", 32'(req_if.addr), 32'(a));
                end
            end
        end
        hold_v     = req_if.req && !req_if.gnt;
        hold_addr  = req_if.addr;
        hold_we    = req_if.we;
        hold_wdata = req_if.wdata;
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = a[11:2];
        pl_data = d;
        model[a[11:2]] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic copy(input string tag, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input int n,
                        input int stall, input bit poke);
        int cyc;
        int d0;
        int r0;
        int b0;
        int want;
        stall_n = stall;
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] sa;
            wr_t w;
            sa     = s + AW'(4 * i);
            w.addr = d + AW'(4 * i);
            w.data = model[sa[11:2]];
            exp_rd.push_back(sa);
            exp_wr.push_back(w);
            model[w.addr[11:2]] = w.data;
        end
        want = (n == 0) ? 1 : n * (4 + 2 * stall) + 1;
        @(negedge clk);
        d0 = done_cnt;
        r0 = req_cnt;
        b0 = busy_cnt;
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = LW'(n);
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && cyc == 3) begin
                start = 1'b1;
                src   = 12'h500;
                dst   = 12'h600;
                len   = 16'd3;
            end
        end while (!done && cyc < 400);
        start = 1'b0;
        check({tag, "_cycles"}, 32'(cyc), 32'(want));
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        if (n == 0) begin
            check({tag, "_no_req"}, 32'(req_cnt - r0), 32'd0);
            check({tag, "_no_busy"}, 32'(busy_cnt - b0), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] da;
            da = d + AW'(4 * i);
            check({tag, "_mem"}, mem[da[11:2]], model[da[11:2]]);
        end
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(req_if.req), 32'd0);
        check("rst_we", 32'(req_if.we), 32'd0);
        check("rst_be", 32'(req_if.be), 32'd0);
        check("rst_addr", 32'(req_if.addr), 32'd0);
        check("rst_wdata", req_if.wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) preload(AW'(4 * i), 32'hA0 + 32'(i));
        copy("basic", 12'h000, 12'h100, 4, 0, 1'b0);

        copy("zero_len", 12'h000, 12'h180, 0, 0, 1'b0);

        preload(12'h040, 32'h1234_5678);
        preload(12'h044, 32'h9ABC_DEF0);
        copy("stall", 12'h040, 12'h200, 2, 3, 1'b0);

        preload(12'h010, 32'hB0);
        preload(12'h014, 32'hB1);
        preload(12'h600, 32'h0BAD_0BAD);
        copy("busy_start", 12'h010, 12'h280, 2, 0, 1'b1);
        check("busy_start_no_write", mem[12'h600 >> 2], 32'h0BAD_0BAD);

        preload(12'hFFC, 32'hC0FF_EE01);
        copy("wrap", 12'hFFC, 12'h400, 2, 0, 1'b0);

        stall_n = 3;
        exp_rd.push_back(12'h000);
        @(negedge clk);
        start = 1'b1;
        src   = 12'h000;
        dst   = 12'h700;
        len   = 16'd2;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(req_if.req && req_if.we) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reached_wr", 32'(req_if.req && req_if.we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_req", 32'(req_if.req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        exp_rd.delete();
        exp_wr.delete();
        preload(12'h020, 32'hDEAD_BEEF);
        copy("after_rst", 12'h020, 12'h708, 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
